// File: rtl/aes_ctr_seq.sv
// aes_ctr_seq: block-level sequencer for AES CTR mode.
// For each requested block it runs one cipher operation and then advances the
// counter, reports progress, and escalates alerts/timeouts into a terminal error.
module aes_ctr_seq #(
  parameter int NumBlkW     = 16,
  parameter int IncrTimeout = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NumBlkW-1:0] num_blks_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic [NumBlkW-1:0] blks_done_o,
  output logic               err_o,
  output logic               cipher_req_o,
  input  logic               cipher_ack_i,
  input  logic               cipher_done_i,
  output logic               ctr_incr_o,
  input  logic               ctr_ready_i,
  input  logic               ctr_alert_i
);

  localparam int TmoW = $clog2(IncrTimeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(IncrTimeout - 1);

  typedef enum logic [2:0] {
    IDLE,
    CIPHER,
    WAIT_CIPHER,
    INCR,
    WAIT_INCR,
    ERROR
  } state_e;

  state_e             state;
  logic [NumBlkW-1:0] total;
  logic               abort_flag;
  logic [TmoW-1:0]    tmo_cnt;
  logic [NumBlkW-1:0] blks_next;
  logic               timeout_hit;
  logic               state_ok;
  logic               to_error;

  assign blks_next   = blks_done_o + NumBlkW'(1);
  assign timeout_hit = (state == WAIT_INCR) && !ctr_ready_i && (tmo_cnt == TmoLast);
  assign state_ok    = state inside {IDLE, CIPHER, WAIT_CIPHER, INCR, WAIT_INCR};
  // Alerts win over every other transition; ERROR and corrupted encodings stay put.
  assign to_error    = ctr_alert_i || timeout_hit || !state_ok;

  // The increment command follows ready directly so the counter FSM sees it in the same cycle.
  assign ctr_incr_o = (state == INCR) && ctr_ready_i;

  // Sequencer state machine with registered status and request outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      err_o        <= 1'b0;
      cipher_req_o <= 1'b0;
      blks_done_o  <= '0;
      total        <= '0;
      abort_flag   <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      done_o <= 1'b0;
      if (busy_o && abort_i) begin
        abort_flag <= 1'b1;
      end
      if (to_error) begin
        state        <= ERROR;
        err_o        <= 1'b1;
        busy_o       <= 1'b0;
        cipher_req_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              if (num_blks_i != '0) begin
                total        <= num_blks_i;
                blks_done_o  <= '0;
                abort_flag   <= 1'b0;
                state        <= CIPHER;
                busy_o       <= 1'b1;
                cipher_req_o <= 1'b1;
              end else begin
                done_o    <= 1'b1;
                aborted_o <= 1'b0;
              end
            end
          end
          CIPHER: begin
            if (cipher_ack_i) begin
              state        <= WAIT_CIPHER;
              cipher_req_o <= 1'b0;
            end
          end
          WAIT_CIPHER: begin
            if (cipher_done_i) begin
              state <= INCR;
            end
          end
          INCR: begin
            if (ctr_ready_i) begin
              tmo_cnt <= '0;
              state   <= WAIT_INCR;
            end
          end
          WAIT_INCR: begin
            if (ctr_ready_i) begin
              blks_done_o <= blks_next;
              if ((blks_next == total) || abort_flag) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                aborted_o <= abort_flag && (blks_next != total);
              end else begin
                state        <= CIPHER;
                cipher_req_o <= 1'b1;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TmoW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_seq.sv
// tb_aes_ctr_seq: directed and randomized bench for aes_ctr_seq with a cycle
// model of the sequencing rules, a cipher responder and an 8-cycle counter model.
module tb_aes_ctr_seq;

  localparam int NumBlkW     = 16;
  localparam int IncrTimeout = 16;

  localparam int M_IDLE   = 0;
  localparam int M_CIPHER = 1;
  localparam int M_WC     = 2;
  localparam int M_INCR   = 3;
  localparam int M_WI     = 4;
  localparam int M_ERR    = 5;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [NumBlkW-1:0] num_blks_i = '0;
  logic abort_i = 1'b0;
  logic ctr_alert_i = 1'b0;
  logic busy_o, done_o, aborted_o, err_o, cipher_req_o, ctr_incr_o;
  logic [NumBlkW-1:0] blks_done_o;
  logic cipher_ack_i, cipher_done_i, ctr_ready_i;

  logic ack_gate = 1'b1;
  logic spur_done = 1'b0;
  logic hang_mode = 1'b0;
  logic hung = 1'b0;
  int lat = 2;
  int dcnt = 0;
  int ccnt = 0;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  int m_mode = M_IDLE;
  logic m_done = 1'b0;
  logic m_ab = 1'b0;
  logic m_flag = 1'b0;
  logic [NumBlkW-1:0] m_blks = '0;
  logic [NumBlkW-1:0] m_total = '0;
  int m_tmo = 0;

  always #5 clk = ~clk;

  assign cipher_ack_i  = cipher_req_o & ack_gate;
  assign cipher_done_i = (dcnt == 1) | spur_done;
  assign ctr_ready_i   = (ccnt == 0) && !hung;

  aes_ctr_seq #(.NumBlkW(NumBlkW), .IncrTimeout(IncrTimeout)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_blks_i(num_blks_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .blks_done_o(blks_done_o), .err_o(err_o), .cipher_req_o(cipher_req_o),
    .cipher_ack_i(cipher_ack_i), .cipher_done_i(cipher_done_i),
    .ctr_incr_o(ctr_incr_o), .ctr_ready_i(ctr_ready_i), .ctr_alert_i(ctr_alert_i)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cipher core and counter FSM behaviour seen by the sequencer.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        dcnt <= 0;
        ccnt <= 0;
        hung <= 1'b0;
      end else begin
        if (cipher_ack_i) dcnt <= lat;
        else if (dcnt != 0) dcnt <= dcnt - 1;
        if (ctr_incr_o) begin
          ccnt <= 8;
          hung <= hang_mode;
        end else if (ccnt != 0) begin
          ccnt <= ccnt - 1;
        end
      end
    end
  end

  // Reference model: compare on the falling edge, snapshot inputs, advance on the rising edge.
  initial begin
    logic s_rst, s_start, s_abort, s_ack, s_cdone, s_ready, s_alert, flag_old;
    logic [NumBlkW-1:0] s_num;
    bit m_busy;
    forever begin
      @(negedge clk);
      m_busy = (m_mode >= M_CIPHER) && (m_mode <= M_WI);
      if (check_en) begin
        checkOutput("busy", busy_o, m_busy);
        checkOutput("done", done_o, m_done);
        checkOutput("err", err_o, m_mode == M_ERR);
        checkOutput("cipher_req", cipher_req_o, m_mode == M_CIPHER);
        checkOutput("ctr_incr", ctr_incr_o, (m_mode == M_INCR) && ctr_ready_i);
        checkOutput("blks_done", blks_done_o, m_blks);
        if (m_done) checkOutput("aborted", aborted_o, m_ab);
      end
      s_rst = rst_i; s_start = start_i; s_num = num_blks_i; s_abort = abort_i;
      s_ack = (m_mode == M_CIPHER) && ack_gate;
      s_cdone = cipher_done_i; s_ready = ctr_ready_i; s_alert = ctr_alert_i;
      @(posedge clk);
      if (s_rst) begin
        m_mode = M_IDLE; m_done = 1'b0; m_ab = 1'b0; m_flag = 1'b0;
        m_blks = '0; m_total = '0; m_tmo = 0;
      end else begin
        flag_old = m_flag;
        m_done = 1'b0;
        if (m_busy && s_abort) m_flag = 1'b1;
        if (s_alert) begin
          m_mode = M_ERR;
        end else begin
          case (m_mode)
            M_IDLE:
              if (s_start) begin
                if (s_num != 0) begin
                  m_total = s_num; m_blks = '0; m_flag = 1'b0; m_mode = M_CIPHER;
                end else begin
                  m_done = 1'b1; m_ab = 1'b0;
                end
              end
            M_CIPHER: if (s_ack) m_mode = M_WC;
            M_WC:     if (s_cdone) m_mode = M_INCR;
            M_INCR:   if (s_ready) begin m_tmo = 0; m_mode = M_WI; end
            M_WI:
              if (s_ready) begin
                m_blks = m_blks + 1'b1;
                if ((m_blks == m_total) || flag_old) begin
                  m_mode = M_IDLE; m_done = 1'b1;
                  m_ab = flag_old && (m_blks != m_total);
                end else begin
                  m_mode = M_CIPHER;
                end
              end else begin
                m_tmo++;
                if (m_tmo >= IncrTimeout) m_mode = M_ERR;
              end
            default: ;
          endcase
        end
      end
    end
  end

  task automatic applyStimulus(input int num, input int l);
    @(posedge clk); #1;
    lat = l; num_blks_i = NumBlkW'(num); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
  endtask

  // Counts cycles after the start-sampling edge until done_o; 0 if it never comes.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int cyc;
    do_reset();
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_blks", blks_done_o, 0);
    checkOutput("reset_busy", busy_o, 0);

    // Three blocks, latency 2: 13 cycles per block, done 40 cycles after start.
    applyStimulus(3, 2);
    wait_done(100, cyc);
    checkOutput("t3_latency", cyc, 40);
    checkOutput("t3_blks", blks_done_o, 3);
    checkOutput("t3_aborted", aborted_o, 0);

    // Zero blocks: done on the very next cycle.
    applyStimulus(0, 2);
    wait_done(10, cyc);
    checkOutput("t0_latency", cyc, 1);
    checkOutput("t0_aborted", aborted_o, 0);

    // Abort during block 2's cipher wait.
    applyStimulus(5, 4);
    for (int i = 0; i < 100; i++) begin
      if (blks_done_o == 1 && cipher_req_o) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    wait_done(100, cyc);
    checkOutput("abort_seen", cyc != 0, 1);
    checkOutput("abort_flag", aborted_o, 1);
    checkOutput("abort_blks", blks_done_o, 2);

    // Counter never becomes ready again: error 16 cycles into WAIT_INCR.
    hang_mode = 1'b1;
    applyStimulus(2, 2);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (err_o) begin cyc = i; break; end
    end
    checkOutput("tmo_latency", cyc, 21);
    applyStimulus(1, 2);
    repeat (3) @(negedge clk);
    checkOutput("tmo_sticky_err", err_o, 1);
    checkOutput("tmo_start_ignored", busy_o, 0);
    hang_mode = 1'b0;
    do_reset();

    // Alert in the same cycle as the cipher acknowledge.
    applyStimulus(3, 2);
    ctr_alert_i = 1'b1;
    @(posedge clk); #1 ctr_alert_i = 1'b0;
    @(negedge clk);
    checkOutput("alert_err", err_o, 1);
    checkOutput("alert_busy", busy_o, 0);
    do_reset();
    @(negedge clk);
    checkOutput("alert_rst_err", err_o, 0);
    checkOutput("alert_rst_blks", blks_done_o, 0);

    // Reset in the middle of block 2 of 4, then a clean single-block run.
    applyStimulus(4, 2);
    for (int i = 0; i < 100; i++) begin
      if (blks_done_o == 1) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    checkOutput("midrst_busy", busy_o, 0);
    applyStimulus(1, 3);
    wait_done(50, cyc);
    checkOutput("midrst_seen", cyc != 0, 1);
    checkOutput("midrst_blks", blks_done_o, 1);

    // Randomized traffic: starts, aborts, ack stalls, latencies and stray done pulses.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start_i    = ($urandom % 6) == 0;
      num_blks_i = NumBlkW'($urandom % 5);
      abort_i    = ((m_mode == M_CIPHER) || (m_mode == M_WC)) && (($urandom % 8) == 0);
      ack_gate   = ($urandom % 3) != 0;
      lat        = 1 + int'($urandom % 4);
      spur_done  = (m_mode == M_IDLE) && (($urandom % 6) == 0);
    end
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0; ack_gate = 1'b1; spur_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_o) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("rand_drained", busy_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_ctr_seq.md
# aes_ctr_seq

Block-level sequencer for AES CTR mode: for each of N requested blocks it starts one cipher operation on the current counter value, waits for the cipher to finish, then commands the counter-increment FSM (`incr`/`ready` handshake, 8 slice cycles per increment) to advance the counter. It sits between the AES control register interface and the cipher core / counter FSM. It also reports progress, and escalates counter alerts or increment timeouts into a terminal error state.

## Interface
- `NumBlkW`, 16: width of block count and progress counter.
- `IncrTimeout`, 16: maximum cycles to wait for `ctr_ready_i` after issuing an increment; must be ≥ 9.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `num_blks_i` in NumBlkW: number of blocks; latched on accepted `start_i`.
- `abort_i` in 1: stop at next block boundary; pulse, captured sticky while busy.
- `busy_o` out 1: high in CIPHER, WAIT_CIPHER, INCR, WAIT_INCR.
- `done_o` out 1: one-cycle pulse on sequence completion (normal or aborted).
- `aborted_o` out 1: valid with `done_o`; 1 if ended by abort.
- `blks_done_o` out NumBlkW: blocks fully completed (cipher plus increment) in current or last sequence.
- `err_o` out 1: high in ERROR.
- `cipher_req_o` out 1: cipher start request; held until acknowledged.
- `cipher_ack_i` in 1: cipher accepted request.
- `cipher_done_i` in 1: cipher result ready (pulse).
- `ctr_incr_o` out 1: increment command to counter FSM.
- `ctr_ready_i` in 1: counter FSM idle/ready.
- `ctr_alert_i` in 1: counter FSM alert.

## Operation
- States: IDLE, CIPHER, WAIT_CIPHER, INCR, WAIT_INCR, ERROR. All state and output registers update on `clk_i`.
- IDLE:
  - On `start_i` with `num_blks_i != 0`: latch count, clear `blks_done_o` and abort flag, go to CIPHER.
  - On `start_i` with `num_blks_i == 0`: pulse `done_o` next cycle (`aborted_o=0`) and stay in IDLE.
- CIPHER: `cipher_req_o=1`. On `cipher_ack_i`, go to WAIT_CIPHER.
- WAIT_CIPHER: on `cipher_done_i`, go to INCR.
  - `cipher_done_i` is ignored outside WAIT_CIPHER.
  - `cipher_done_i` arrives at least 1 cycle after ack.
- INCR: `ctr_incr_o = ctr_ready_i` (combinational, this state only). When it is 1, clear the timeout counter and go to WAIT_INCR.
- WAIT_INCR:
  - Timeout counter increments each cycle.
  - On `ctr_ready_i=1`: `blks_done_o+1`.
    - If the new count equals the latched count, or the abort flag is set: go to IDLE, pulse `done_o`, set `aborted_o` = abort flag && (count not reached).
    - Otherwise go to CIPHER.
  - Counter reaching `IncrTimeout` without ready: go to ERROR.
- The last block is also incremented, so the counter always points at the next unused value.
- Abort:
  - `abort_i` in any busy state sets the flag.
  - It never cancels an in-flight cipher or increment; it is honoured only at the WAIT_INCR exit.
  - `abort_i` in IDLE is ignored.
- ERROR:
  - Entered from any state when `ctr_alert_i=1` (highest priority, overrides all transitions that cycle), or on timeout.
  - Terminal: `err_o=1`, all requests 0, `start_i` ignored. Left only by `rst_i`.
- Unreachable state encodings go to ERROR.
- `blks_done_o` wraps modulo 2^NumBlkW; it never exceeds the latched count in practice.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `aborted_o`, `err_o`, `cipher_req_o`, `ctr_incr_o` = 0; `blks_done_o` = 0; abort flag and timeout counter = 0.
- Reset asserted mid-sequence returns to IDLE at the next edge with no `done_o`.
- `start_i` at cycle t gives `cipher_req_o=1` and `busy_o=1` at t+1.
- Ack at cycle a gives WAIT_CIPHER at a+1. Done at d gives INCR at d+1, and `ctr_incr_o` at d+1 if ready.
- Ready returning at r gives `blks_done_o` updated at r+1, plus either `cipher_req_o` at r+1 or `done_o` at r+1.
- Per block with 0-wait ack, cipher latency L (done at ack+L), and 8-cycle increment: 1 + L + 1 + 9 cycles.
- `done_o` is high for exactly one cycle, the same cycle the block returns to IDLE. A new `start_i` in that cycle is accepted.

## Test plan
- `num_blks_i=3`, ack immediate, done 2 cycles after ack, counter model with 8-cycle increment → three `cipher_req_o`/`ctr_incr_o` pairs, `blks_done_o` 1,2,3, single `done_o` with `aborted_o=0`, `busy_o` low after.
- `num_blks_i=0` → `done_o` at t+1, no `cipher_req_o`, `busy_o` never high.
- `num_blks_i=5`, `abort_i` pulsed during block 2's WAIT_CIPHER → block 2 completes including increment, `done_o` with `aborted_o=1`, `blks_done_o=2`.
- Counter model never raises ready after incr, `IncrTimeout=16` → ERROR 16 cycles after entering WAIT_INCR, `err_o=1`, later `start_i` ignored until `rst_i`.
- `ctr_alert_i` in the same cycle as `cipher_ack_i` → ERROR next cycle, no WAIT_CIPHER; `rst_i` then restores all reset values.
- `rst_i` during block 2 of 4 → IDLE next cycle, no `done_o`; fresh `start_i` with `num_blks_i=1` completes normally with `blks_done_o=1`.
